// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ writeback sources.
// Defining WB_ARB_BYPASS_EN adds the early-forwarding outputs byp_valid, byp_rd and byp_data.

module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = 64,
    parameter int AW   = 5,
    parameter int CNTW = 16,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 wb_en,
    input  logic                 flush,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_rd,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic [NREQ-1:0]      req_ready,
    output logic                 RegWrite,
    output logic [AW-1:0]        rd,
    output logic [DW-1:0]        wdata,
    output logic [IW-1:0]        grant_id,
    output logic [CNTW-1:0]      conflict_cnt
`ifdef WB_ARB_BYPASS_EN
    ,
    output logic                 byp_valid,
    output logic [AW-1:0]        byp_rd,
    output logic [DW-1:0]        byp_data
`endif
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] winner;
    logic          found;
    logic [IW:0]   idx;
    logic [AW-1:0] win_rd;
    logic [DW-1:0] win_data;
    logic          xfer;
    logic          conflict;

    // Search from ptr upward, wrapping modulo NREQ; the first valid requester wins.
    always_comb begin
        req_ready = '0;
        winner    = '0;
        found     = 1'b0;
        idx       = '0;
        if (wb_en && !flush) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = {1'b0, ptr} + (IW+1)'(k);
                if (idx >= (IW+1)'(NREQ)) begin
                    idx = idx - (IW+1)'(NREQ);
                end
                if (!found && req_valid[idx[IW-1:0]]) begin
                    found  = 1'b1;
                    winner = idx[IW-1:0];
                end
            end
        end
        if (found) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_comb begin
        win_rd   = '0;
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                win_rd   = req_rd[i*AW +: AW];
                win_data = req_wdata[i*DW +: DW];
            end
        end
    end

    assign xfer     = |(req_valid & req_ready);
    assign conflict = ($countones(req_valid) >= 2);

    // Flush only clears the write strobe and pointer; the last written rd/wdata stay visible.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            RegWrite     <= 1'b0;
            rd           <= '0;
            wdata        <= '0;
            grant_id     <= '0;
            ptr          <= '0;
            conflict_cnt <= '0;
        end else begin
            if (flush) begin
                RegWrite <= 1'b0;
                ptr      <= '0;
            end else if (xfer) begin
                RegWrite <= (win_rd != '0);
                rd       <= win_rd;
                wdata    <= win_data;
                grant_id <= winner;
                ptr      <= (winner == IW'(NREQ-1)) ? '0 : winner + 1'b1;
            end else begin
                RegWrite <= 1'b0;
            end
            if (conflict && (conflict_cnt != '1)) begin
                conflict_cnt <= conflict_cnt + 1'b1;
            end
        end
    end

`ifdef WB_ARB_BYPASS_EN
    // Forward the transfer happening now so consumers see it a cycle before the register file.
    assign byp_valid = xfer && (win_rd != '0);
    assign byp_rd    = win_rd;
    assign byp_data  = win_data;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed vector table, saturation sequence and
// randomized holding requesters checked against a behavioural round-robin model.

module tb_regfile_wb_arbiter;

    localparam int NREQ = 3;
    localparam int DW   = 64;
    localparam int AW   = 5;
    localparam int CNTW = 4;
    localparam int MAXCNT = (1 << CNTW) - 1;

    logic                 CLK;
    logic                 nRST;
    logic                 wb_en;
    logic                 flush;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_rd;
    logic [NREQ*DW-1:0]   req_wdata;
    logic [NREQ-1:0]      req_ready;
    logic                 RegWrite;
    logic [AW-1:0]        rd;
    logic [DW-1:0]        wdata;
    logic [1:0]           grant_id;
    logic [CNTW-1:0]      conflict_cnt;
`ifdef WB_ARB_BYPASS_EN
    logic                 byp_valid;
    logic [AW-1:0]        byp_rd;
    logic [DW-1:0]        byp_data;
`endif

    regfile_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .CNTW(CNTW)) dut (
        .CLK(CLK),
        .nRST(nRST),
        .wb_en(wb_en),
        .flush(flush),
        .req_valid(req_valid),
        .req_rd(req_rd),
        .req_wdata(req_wdata),
        .req_ready(req_ready),
        .RegWrite(RegWrite),
        .rd(rd),
        .wdata(wdata),
        .grant_id(grant_id),
        .conflict_cnt(conflict_cnt)
`ifdef WB_ARB_BYPASS_EN
        ,
        .byp_valid(byp_valid),
        .byp_rd(byp_rd),
        .byp_data(byp_data)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    int          m_ptr;
    int          m_win;
    logic        m_rw;
    logic [4:0]  m_rd;
    logic [63:0] m_wd;
    int          m_gid;
    int          m_cnt;
    logic [2:0]  sampled_ready;

    typedef struct {
        logic         nrst;
        logic         en;
        logic         fl;
        logic [2:0]   valid;
        logic [14:0]  rdv;
        logic [2:0]   exp_ready;
        logic         exp_rw;
        logic [4:0]   exp_rd;
        logic [63:0]  exp_wd;
        logic [1:0]   exp_gid;
    } vec_t;

    localparam logic [63:0]  D0 = 64'hC0DE_0000_0000_0A0A;
    localparam logic [63:0]  D1 = 64'h0000_0000_DEAD_BEEF;
    localparam logic [63:0]  D2 = 64'hC0DE_0002_1234_5678;
    localparam logic [191:0] WALL = {D2, D1, D0};
    localparam logic [14:0]  RALL = {5'd7, 5'd5, 5'd3};
    localparam logic [14:0]  RZ0  = {5'd7, 5'd5, 5'd0};

    vec_t vecs[14];

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle, check the combinational grant, then advance the model across the edge.
    task automatic applyStimulus(input logic n, input logic e, input logic f,
                                 input logic [2:0] v, input logic [14:0] r, input logic [191:0] w);
        logic [2:0] exp_ready;
        nRST = n; wb_en = e; flush = f;
        req_valid = v; req_rd = r; req_wdata = w;
        #1;
        m_win = -1;
        if (n && e && !f) begin
            for (int k = 0; k < NREQ; k++) begin
                int id;
                id = (m_ptr + k) % NREQ;
                if (m_win < 0 && v[id]) m_win = id;
            end
        end
        exp_ready = (m_win >= 0) ? 3'(1 << m_win) : 3'b000;
        sampled_ready = req_ready;
        if (n) begin
            check_val("req_ready", {61'd0, req_ready}, {61'd0, exp_ready});
`ifdef WB_ARB_BYPASS_EN
            check_val("byp_valid", {63'd0, byp_valid},
                      {63'd0, (m_win >= 0) && (r[m_win*AW +: AW] != 5'd0)});
            if (m_win >= 0) check_val("byp_rd", {59'd0, byp_rd}, {59'd0, r[m_win*AW +: AW]});
`endif
        end
        @(posedge CLK);
        if (!n) begin
            m_rw = 1'b0; m_rd = '0; m_wd = '0; m_gid = 0; m_ptr = 0; m_cnt = 0;
        end else begin
            if (f) begin
                m_rw = 1'b0;
                m_ptr = 0;
            end else if (m_win >= 0) begin
                m_rd  = r[m_win*AW +: AW];
                m_rw  = (m_rd != 5'd0);
                m_wd  = w[m_win*DW +: DW];
                m_gid = m_win;
                m_ptr = (m_win + 1) % NREQ;
            end else begin
                m_rw = 1'b0;
            end
            if ($countones(v) >= 2 && m_cnt < MAXCNT) m_cnt++;
        end
        #1;
    endtask

    task automatic checkOutput();
        check_val("RegWrite", {63'd0, RegWrite}, {63'd0, m_rw});
        check_val("rd", {59'd0, rd}, {59'd0, m_rd});
        check_val("wdata", wdata, m_wd);
        check_val("grant_id", {62'd0, grant_id}, 64'(m_gid));
        check_val("conflict_cnt", {60'd0, conflict_cnt}, 64'(m_cnt));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int          pend[3];
        logic [4:0]  prd[3];
        logic [63:0] pdat[3];
        int          waitc[3];
        logic [2:0]  v;
        logic [14:0] r;
        logic [191:0] w;
        logic        e;
        logic        f;

        m_ptr = 0; m_rw = 0; m_rd = 0; m_wd = 0; m_gid = 0; m_cnt = 0;

        //              nrst  en    fl    valid   rdv   ready   rw    rd     wdata gid
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 3'b111, RALL, 3'b001, 1'b1, 5'd3, D0, 2'd0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 3'b010, RALL, 3'b010, 1'b1, 5'd5, D1, 2'd1};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 3'b111, RALL, 3'b000, 1'b0, 5'd5, D1, 2'd1};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 3'b111, RALL, 3'b001, 1'b1, 5'd3, D0, 2'd0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 3'b111, RALL, 3'b010, 1'b1, 5'd5, D1, 2'd1};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 3'b111, RALL, 3'b100, 1'b1, 5'd7, D2, 2'd2};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 3'b111, RALL, 3'b001, 1'b1, 5'd3, D0, 2'd0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 3'b111, RALL, 3'b010, 1'b1, 5'd5, D1, 2'd1};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 3'b111, RALL, 3'b100, 1'b1, 5'd7, D2, 2'd2};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 3'b001, RZ0,  3'b001, 1'b0, 5'd0, D0, 2'd0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 3'b111, RALL, 3'b000, 1'b0, 5'd0, D0, 2'd0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 3'b111, RALL, 3'b010, 1'b1, 5'd5, D1, 2'd1};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 3'b000, RALL, 3'b000, 1'b0, 5'd5, D1, 2'd1};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 3'b101, RALL, 3'b100, 1'b1, 5'd7, D2, 2'd2};

        $display("[TB] reset with all requesters valid");
        applyStimulus(1'b0, 1'b1, 1'b0, 3'b111, RALL, WALL);
        applyStimulus(1'b0, 1'b1, 1'b0, 3'b111, RALL, WALL);
        check_val("reset_RegWrite", {63'd0, RegWrite}, 64'd0);
        check_val("reset_rd", {59'd0, rd}, 64'd0);
        check_val("reset_conflict_cnt", {60'd0, conflict_cnt}, 64'd0);
        check_val("reset_grant_id", {62'd0, grant_id}, 64'd0);
        checkOutput();

        $display("[TB] directed vector table");
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].nrst, vecs[i].en, vecs[i].fl, vecs[i].valid, vecs[i].rdv, WALL);
            check_val($sformatf("vec%0d_ready", i), {61'd0, sampled_ready}, {61'd0, vecs[i].exp_ready});
            check_val($sformatf("vec%0d_RegWrite", i), {63'd0, RegWrite}, {63'd0, vecs[i].exp_rw});
            check_val($sformatf("vec%0d_rd", i), {59'd0, rd}, {59'd0, vecs[i].exp_rd});
            check_val($sformatf("vec%0d_wdata", i), wdata, vecs[i].exp_wd);
            check_val($sformatf("vec%0d_grant_id", i), {62'd0, grant_id}, {62'd0, vecs[i].exp_gid});
            checkOutput();
        end

        $display("[TB] conflict counter saturation");
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, RALL, WALL);
        checkOutput();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 3'b011, RALL, WALL);
            checkOutput();
        end
        check_val("conflict_cnt_saturated", {60'd0, conflict_cnt}, 64'(MAXCNT));

        $display("[TB] randomized holding requesters");
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 0; prd[i] = '0; pdat[i] = '0; waitc[i] = 0;
        end
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (pend[i] == 0 && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1;
                    prd[i]  = 5'($urandom_range(0, 31));
                    pdat[i] = {$urandom, $urandom};
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                v[i] = (pend[i] != 0);
                r[i*AW +: AW] = prd[i];
                w[i*DW +: DW] = pdat[i];
            end
            e = ($urandom_range(0, 7) != 0);
            f = ($urandom_range(0, 15) == 0);
            applyStimulus(1'b1, e, f, v, r, w);
            checkOutput();
            for (int i = 0; i < NREQ; i++) begin
                if (v[i] && sampled_ready[i]) begin
                    pend[i] = 0;
                    waitc[i] = 0;
                end else if (v[i] && e && !f) begin
                    waitc[i]++;
                end else begin
                    waitc[i] = 0;
                end
                check_val($sformatf("fairness_wait_%0d", i), 64'(waitc[i] >= NREQ), 64'd0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
